// File: rtl/led_fade_trail_pkg.sv
// Shared constants for the LED fade-trail block: LED count, default PWM depth
// and the board-clock prescaler defaults.
package led_pkg;
    localparam int LED_COUNT    = 8;
    localparam int PWM_BITS_DEF = 4;
    localparam int MAX_LEVEL    = (1 << PWM_BITS_DEF) - 1;
    localparam int PWM_DIV_DEF  = 256;
    localparam int FADE_DIV_DEF = 3_125_000;

    function automatic int max_level(input int bits);
        return (1 << bits) - 1;
    endfunction

    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction
endpackage

// File: rtl/led_fade_trail_if.sv
// Pattern bus between the running-LED sequencer and the fade-trail driver.
interface led_fade_trail_if;
    import led_pkg::*;

    logic [LED_COUNT-1:0] led_in;
    logic                 bypass;
    logic [LED_COUNT-1:0] led_out;
    logic                 fade_tick;

    modport master (output led_in, output bypass, input led_out, input fade_tick);
    modport slave  (input led_in, input bypass, output led_out, output fade_tick);
endinterface

// File: rtl/led_fade_trail_channel.sv
// One LED: brightness level register with load/decay and the PWM compare that
// produces the registered pin drive.
module led_fade_channel #(
    parameter int PWM_BITS   = 4,
    parameter int DECAY_STEP = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic                i_fade_tick,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic                i_bypass,
    output logic                o_led
);
    localparam logic [PWM_BITS-1:0] MAX_LVL = '1;
    localparam logic [PWM_BITS-1:0] DEC     = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0] r_level;
    logic                r_led;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
            r_led   <= 1'b0;
        end else begin
            // A fresh load wins over a coincident decay step.
            if (i_load)
                r_level <= MAX_LVL;
            else if (i_fade_tick)
                r_level <= (r_level < DEC) ? '0 : r_level - DEC;

            r_led <= i_bypass ? i_load : (r_level > i_pwm_cnt);
        end
    end

    assign o_led = r_led;
endmodule

// File: rtl/led_fade_trail.sv
// Comet-tail driver for the running-LED pattern: fade prescaler, shared PWM
// counter and one fade channel per LED.
module led_fade_trail
    import led_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int PWM_DIV    = PWM_DIV_DEF,
    parameter int FADE_DIV   = FADE_DIV_DEF,
    parameter int DECAY_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    led_fade_trail_if.slave  bus
);
    localparam int FW = cnt_width(FADE_DIV);
    localparam int PW = cnt_width(PWM_DIV);

    localparam logic [FW-1:0]       FADE_LAST    = FW'(FADE_DIV - 1);
    localparam logic [PW-1:0]       PWM_PRE_LAST = PW'(PWM_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_CNT_LAST = PWM_BITS'(max_level(PWM_BITS) - 1);

    logic [FW-1:0]        r_fade_cnt;
    logic [PW-1:0]        r_pwm_pre;
    logic [PWM_BITS-1:0]  r_pwm_cnt;
    logic                 w_fade_tick;
    logic                 w_pwm_wrap;
    logic [LED_COUNT-1:0] w_led;

    assign w_fade_tick = (r_fade_cnt == FADE_LAST);
    assign w_pwm_wrap  = (r_pwm_pre == PWM_PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fade_cnt <= '0;
            r_pwm_pre  <= '0;
            r_pwm_cnt  <= '0;
        end else begin
            r_fade_cnt <= w_fade_tick ? '0 : r_fade_cnt + 1'b1;
            r_pwm_pre  <= w_pwm_wrap ? '0 : r_pwm_pre + 1'b1;
            // pwm_cnt stops at MAX-1 so a full-scale level is never compared off.
            if (w_pwm_wrap)
                r_pwm_cnt <= (r_pwm_cnt == PWM_CNT_LAST) ? '0 : r_pwm_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < LED_COUNT; g++) begin : g_chan
        led_fade_channel #(
            .PWM_BITS   (PWM_BITS),
            .DECAY_STEP (DECAY_STEP)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .i_load      (bus.led_in[g]),
            .i_fade_tick (w_fade_tick),
            .i_pwm_cnt   (r_pwm_cnt),
            .i_bypass    (bus.bypass),
            .o_led       (w_led[g])
        );
    end

    assign bus.led_out   = w_led;
    assign bus.fade_tick = w_fade_tick;
endmodule
